mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back formatter of the 32-bit MIPS core; sits directly upstream of the register file.
- Captures ALU result and data-memory read data, performs load byte/halfword extraction and extension, and selects the write-back value.
- Drives the register file's writeadd/writedata/RegWrite inputs and a forwarding tap; also counts retired instructions.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.
- COUNT_W, 32, retired-instruction counter width.

Ports:
- clk  in  1  core clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hold all pipeline state.
- flush  in  1  kill the instruction being captured.
- in_valid  in  1  MEM stage holds a real instruction.
- in_regwrite  in  2  00 none, 01 write, 10 lui, 11 write.
- in_memtoreg  in  1  1 = write-back value comes from memory.
- in_loadtype  in  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; others illegal.
- in_writeadd  in  ADDR_W  destination register.
- in_aluresult  in  DATA_W  ALU result; also the load byte address.
- in_memdata  in  DATA_W  word read from data memory.
- writeadd  out  ADDR_W  to register file.
- writedata  out  DATA_W  to register file.
- RegWrite  out  2  to register file, same encoding as in_regwrite.
- wb_valid  out  1  write-back slot holds a valid instruction.
- fwd_en, fwd_add, fwd_data  out  1/ADDR_W/DATA_W  forwarding tap to the EX stage.
- misalign  out  1  one-cycle flag: captured load was misaligned.
- retired_count  out  COUNT_W  retired-instruction counter.

Behaviour:
- Bit 0 is the MSB on all buses. Memory is big-endian: byte offset 0 is bits [0:7].
- Reset: all outputs and state are 0; RegWrite=00.
- Capture: registered, one-cycle latency. The edge after inputs are presented, the outputs reflect them.
  - Outputs are stable for the full cycle, so the register file's negedge write sees settled values.
- Priority at posedge: reset > flush > stall > capture.
  - flush: wb_valid=0, RegWrite=00, misalign=0; the other data fields are don't-care but are held.
  - stall (no flush): all registers hold; the counter does not increment.
- The slot is valid iff in_valid=1. An invalid slot forces RegWrite=00.
- Write-back value:
  - in_memtoreg=0 or in_regwrite=10: in_aluresult, passed unchanged.
  - in_memtoreg=1: the formatted load, using offset = in_aluresult[30:31].
    - lw: the full word.
    - lb/lbu: the byte selected by offset, sign- or zero-extended to 32 bits.
    - lh/lhu: offset 00 gives bits [0:15], offset 10 gives [16:31], sign- or zero-extended.
- Misalignment: lw with offset≠00, lh/lhu with offset 01/11, or an illegal loadtype while memtoreg=1.
  - Effects: misalign=1 for one cycle, RegWrite forced to 00, instruction still counted as retired.
- in_writeadd=0 forces RegWrite=00 (the register file does not protect $0). No misalign is raised for this case.
- Forwarding tap:
  - fwd_en = wb_valid & (RegWrite≠00).
  - fwd_add = writeadd.
  - fwd_data = writedata, except for lui (RegWrite=10), where it is {writedata[16:31], 16'b0}, matching what the register file stores.
- retired_count increments by 1 on each capture edge with in_valid=1 and no reset, flush or stall. It wraps from all-ones to 0.

Decomposition:
- Shared package holds:
  - the RegWrite encodings (RW_NONE=00, RW_WR=01, RW_LUI=10, RW_WR2=11);
  - the loadtype encodings;
  - DATA_W and ADDR_W constants.
- One combinational sub-module, load_formatter: inputs memdata, offset and loadtype; outputs the formatted word and the misaligned flag.
- Pipeline registers and the counter live in the top.

Test Plan:
1. Reset held 2 cycles, then released → RegWrite=00, writedata=0, retired_count=0, wb_valid=0.
2. Valid ALU write: writeadd=8, aluresult=0x0000_0007, regwrite=01 → next edge: RegWrite=01, writedata=7, fwd_en=1, retired_count=1.
3. Loads with memdata=0x80FF_7F01:
   - lb, addr 0x...00 → 0xFFFF_FF80.
   - lbu, addr 0x...01 → 0x0000_00FF.
   - lh, addr 0x...02 → 0x0000_7F01.
   - lhu, addr 0x...00 → 0x0000_80FF.
4. lh at addr 0x...01 → misalign=1 for exactly one cycle, RegWrite=00, counter still increments.
5. lui: regwrite=10, aluresult=0x0000_1234 → writedata=0x0000_1234, RegWrite=10, fwd_data=0x1234_0000. Separately, a write to $0 → RegWrite=00.
6. Control priority:
   - stall for 3 cycles → outputs and counter frozen.
   - stall and flush together → RegWrite=00, wb_valid=0.
   - counter preloaded near max, one more retire → wraps from 0xFFFF_FFFF to 0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings and widths for the MEM/WB write-back stage.
package mem_wb_stage_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [1:0] {
        RW_NONE = 2'b00,
        RW_WR   = 2'b01,
        RW_LUI  = 2'b10,
        RW_WR2  = 2'b11
    } regwrite_e;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } loadtype_e;

endpackage

// File: rtl/mem_wb_stage_load_formatter.sv
// Big-endian load extraction/extension of a 32-bit memory word; purely combinational.
module load_formatter
    import mem_wb_stage_pkg::*;
(
    input  logic [0:DATA_W-1] memdata,
    input  logic [0:1]        offset,
    input  logic [2:0]        loadtype,
    output logic [0:DATA_W-1] formatted,
    output logic              misaligned
);

    logic [0:7]  byte_sel;
    logic [0:15] half_sel;

    always_comb begin
        // Byte offset 0 is the most significant byte of the word.
        case (offset)
            2'd0:    byte_sel = memdata[0:7];
            2'd1:    byte_sel = memdata[8:15];
            2'd2:    byte_sel = memdata[16:23];
            default: byte_sel = memdata[24:31];
        endcase
        half_sel = offset[0] ? memdata[16:31] : memdata[0:15];

        formatted  = memdata;
        misaligned = 1'b0;
        case (loadtype)
            LT_LW:  misaligned = (offset != 2'b00);
            LT_LB:  formatted  = {{24{byte_sel[0]}}, byte_sel};
            LT_LBU: formatted  = {24'b0, byte_sel};
            LT_LH: begin
                formatted  = {{16{half_sel[0]}}, half_sel};
                misaligned = offset[1];
            end
            LT_LHU: begin
                formatted  = {16'b0, half_sel};
                misaligned = offset[1];
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats loads, selects write-back value, drives regfile and forwarding tap.
module mem_wb_stage
#(
    parameter int DATA_W  = mem_wb_stage_pkg::DATA_W,
    parameter int ADDR_W  = mem_wb_stage_pkg::ADDR_W,
    parameter int COUNT_W = 32
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [1:0]          in_regwrite,
    input  logic                in_memtoreg,
    input  logic [2:0]          in_loadtype,
    input  logic [0:ADDR_W-1]   in_writeadd,
    input  logic [0:DATA_W-1]   in_aluresult,
    input  logic [0:DATA_W-1]   in_memdata,
    output logic [0:ADDR_W-1]   writeadd,
    output logic [0:DATA_W-1]   writedata,
    output logic [1:0]          RegWrite,
    output logic                wb_valid,
    output logic                fwd_en,
    output logic [0:ADDR_W-1]   fwd_add,
    output logic [0:DATA_W-1]   fwd_data,
    output logic                misalign,
    output logic [COUNT_W-1:0]  retired_count
);
    import mem_wb_stage_pkg::*;

    logic [0:DATA_W-1] fmt_data;
    logic              fmt_misaligned;
    logic              use_mem;
    logic [0:DATA_W-1] wb_value;
    logic              mis_next;
    logic [1:0]        rw_next;

    load_formatter u_fmt (
        .memdata    (in_memdata),
        .offset     (in_aluresult[DATA_W-2:DATA_W-1]),
        .loadtype   (in_loadtype),
        .formatted  (fmt_data),
        .misaligned (fmt_misaligned)
    );

    // lui always writes back the raw ALU result, even if memtoreg is set.
    assign use_mem  = in_memtoreg && (in_regwrite != RW_LUI);
    assign wb_value = use_mem ? fmt_data : in_aluresult;
    assign mis_next = in_valid && use_mem && fmt_misaligned;
    assign rw_next  = (!in_valid || mis_next || (in_writeadd == '0)) ? RW_NONE : in_regwrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            writeadd      <= '0;
            writedata     <= '0;
            RegWrite      <= RW_NONE;
            wb_valid      <= 1'b0;
            misalign      <= 1'b0;
            retired_count <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            RegWrite <= RW_NONE;
            misalign <= 1'b0;
        end else if (!stall) begin
            writeadd  <= in_writeadd;
            writedata <= wb_value;
            RegWrite  <= rw_next;
            wb_valid  <= in_valid;
            misalign  <= mis_next;
            if (in_valid) begin
                retired_count <= retired_count + COUNT_W'(1);
            end
        end
    end

    // The register file shifts lui data into the upper half; forward what it will store.
    assign fwd_en   = wb_valid && (RegWrite != RW_NONE);
    assign fwd_add  = writeadd;
    assign fwd_data = (RegWrite == RW_LUI)
                    ? {writedata[DATA_W/2:DATA_W-1], {(DATA_W/2){1'b0}}}
                    : writedata;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_mem_wb_stage;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset, stall, flush, in_valid, in_memtoreg;
    logic [1:0]    in_regwrite;
    logic [2:0]    in_loadtype;
    logic [0:AW-1] in_writeadd;
    logic [0:DW-1] in_aluresult, in_memdata;
    logic [0:AW-1] writeadd, fwd_add;
    logic [0:DW-1] writedata, fwd_data;
    logic [1:0]    RegWrite;
    logic          wb_valid, fwd_en, misalign;
    logic [CW-1:0] retired_count;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model of the write-back slot
    logic        m_valid, m_mis;
    logic [1:0]  m_rw;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    int          m_cnt;

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(DW), .ADDR_W(AW), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_loadtype(in_loadtype), .in_writeadd(in_writeadd),
        .in_aluresult(in_aluresult), .in_memdata(in_memdata),
        .writeadd(writeadd), .writedata(writedata), .RegWrite(RegWrite),
        .wb_valid(wb_valid), .fwd_en(fwd_en), .fwd_add(fwd_add), .fwd_data(fwd_data),
        .misalign(misalign), .retired_count(retired_count)
    );

    // Returns {misaligned, write-back value}; byte 0 is the most significant byte.
    function automatic logic [32:0] model_wb(logic mtr, logic [1:0] rw, logic [2:0] lt,
                                             logic [31:0] alu, logic [31:0] mem);
        int          off;
        logic [7:0]  b;
        logic [15:0] h;
        off = int'(alu[1:0]);
        b   = 8'(mem >> (8 * (3 - off)));
        h   = 16'(mem >> ((off >= 2) ? 0 : 16));
        if (!mtr || rw == 2'b10) return {1'b0, alu};
        case (lt)
            3'd0:    return {off != 0, mem};
            3'd1:    return {1'b0, {{24{b[7]}}, b}};
            3'd2:    return {1'b0, 24'h0, b};
            3'd3:    return {(off % 2) == 1, {{16{h[15]}}, h}};
            3'd4:    return {(off % 2) == 1, 16'h0, h};
            default: return {1'b1, mem};
        endcase
    endfunction

    task automatic cycle();
        logic [32:0] r;
        logic        v, fl, st, rs;
        logic [1:0]  rw;
        logic [4:0]  wa;
        r  = model_wb(in_memtoreg, in_regwrite, in_loadtype, in_aluresult, in_memdata);
        v  = in_valid; fl = flush; st = stall; rs = reset; rw = in_regwrite; wa = in_writeadd;
        @(posedge clk);
        #1;
        if (rs) begin
            m_valid = 0; m_mis = 0; m_rw = 0; m_wa = 0; m_wd = 0; m_cnt = 0;
        end else if (fl) begin
            m_valid = 0; m_rw = 0; m_mis = 0;
        end else if (!st) begin
            m_valid = v;
            m_wa    = wa;
            m_wd    = r[31:0];
            m_mis   = v && r[32];
            m_rw    = (!v || m_mis || wa == 0) ? 2'b00 : rw;
            if (v) m_cnt = (m_cnt + 1) % (1 << CW);
        end
    endtask

    task automatic set_op(logic v, logic [1:0] rw, logic mtr, logic [2:0] lt,
                          logic [4:0] wa, logic [31:0] alu, logic [31:0] mem);
        in_valid = v; in_regwrite = rw; in_memtoreg = mtr; in_loadtype = lt;
        in_writeadd = wa; in_aluresult = alu; in_memdata = mem;
    endtask

    task automatic test_reset();
        reset = 1; stall = 0; flush = 0;
        set_op(0, 2'b00, 0, 3'd0, 5'd0, 32'h0, 32'h0);
        cycle();
        cycle();
        reset = 0;
        cycle();
        n_vec++; if (RegWrite !== 2'b00) begin n_err++; $display("FAIL reset_regwrite got %0h want 0", RegWrite); end
        n_vec++; if (writedata !== 32'h0) begin n_err++; $display("FAIL reset_writedata got %0h want 0", writedata); end
        n_vec++; if (retired_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", retired_count); end
        n_vec++; if (wb_valid !== 1'b0 || misalign !== 1'b0 || fwd_en !== 1'b0) begin
            n_err++; $display("FAIL reset_flags got v=%b m=%b f=%b want 0", wb_valid, misalign, fwd_en);
        end
    endtask

    task automatic test_alu_write();
        set_op(1, 2'b01, 0, 3'd0, 5'd8, 32'h0000_0007, 32'hDEAD_BEEF);
        cycle();
        n_vec++; if (RegWrite !== 2'b01) begin n_err++; $display("FAIL alu_regwrite got %0h want 1", RegWrite); end
        n_vec++; if (writedata !== 32'h7 || writeadd !== 5'd8) begin
            n_err++; $display("FAIL alu_data got %0h@%0d want 7@8", writedata, writeadd);
        end
        n_vec++; if (fwd_en !== 1'b1 || fwd_data !== 32'h7 || fwd_add !== 5'd8) begin
            n_err++; $display("FAIL alu_fwd got en=%b %0h@%0d want 1 7@8", fwd_en, fwd_data, fwd_add);
        end
        n_vec++; if (retired_count !== 8'd1) begin n_err++; $display("FAIL alu_count got %0d want 1", retired_count); end
    endtask

    task automatic test_loads();
        logic [2:0]  lts [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [31:0] adr [4] = '{32'h100, 32'h101, 32'h102, 32'h100};
        logic [31:0] exp [4] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'h0000_7F01, 32'h0000_80FF};
        for (int i = 0; i < 4; i++) begin
            set_op(1, 2'b01, 1, lts[i], 5'd3, adr[i], 32'h80FF_7F01);
            cycle();
            n_vec++; if (writedata !== exp[i] || RegWrite !== 2'b01 || misalign !== 1'b0) begin
                n_err++; $display("FAIL load_%0d got %0h rw=%0h mis=%b want %0h rw=1 mis=0",
                                  i, writedata, RegWrite, misalign, exp[i]);
            end
        end
    endtask

    task automatic test_misalign();
        int c0;
        c0 = m_cnt;
        set_op(1, 2'b01, 1, 3'd3, 5'd5, 32'h101, 32'h80FF_7F01);
        cycle();
        n_vec++; if (misalign !== 1'b1 || RegWrite !== 2'b00 || fwd_en !== 1'b0) begin
            n_err++; $display("FAIL misalign_set got m=%b rw=%0h f=%b want 1 0 0", misalign, RegWrite, fwd_en);
        end
        n_vec++; if (int'(retired_count) !== (c0 + 1) % (1 << CW)) begin
            n_err++; $display("FAIL misalign_count got %0d want %0d", retired_count, (c0 + 1) % (1 << CW));
        end
        set_op(1, 2'b01, 0, 3'd0, 5'd5, 32'h42, 32'h0);
        cycle();
        n_vec++; if (misalign !== 1'b0 || RegWrite !== 2'b01) begin
            n_err++; $display("FAIL misalign_clear got m=%b rw=%0h want 0 1", misalign, RegWrite);
        end
    endtask

    task automatic test_lui_and_zero();
        set_op(1, 2'b10, 0, 3'd0, 5'd9, 32'h0000_1234, 32'h0);
        cycle();
        n_vec++; if (writedata !== 32'h1234 || RegWrite !== 2'b10) begin
            n_err++; $display("FAIL lui_wb got %0h rw=%0h want 1234 rw=2", writedata, RegWrite);
        end
        n_vec++; if (fwd_data !== 32'h1234_0000 || fwd_en !== 1'b1) begin
            n_err++; $display("FAIL lui_fwd got %0h en=%b want 12340000 en=1", fwd_data, fwd_en);
        end
        set_op(1, 2'b01, 0, 3'd0, 5'd0, 32'h55, 32'h0);
        cycle();
        n_vec++; if (RegWrite !== 2'b00 || fwd_en !== 1'b0 || misalign !== 1'b0 || wb_valid !== 1'b1) begin
            n_err++; $display("FAIL zero_reg got rw=%0h f=%b m=%b v=%b want 0 0 0 1", RegWrite, fwd_en, misalign, wb_valid);
        end
    endtask

    task automatic test_stall_flush();
        logic [CW-1:0] c0;
        set_op(1, 2'b01, 0, 3'd0, 5'd4, 32'h0000_ABCD, 32'h0);
        cycle();
        c0 = retired_count;
        n_vec++; if (int'(c0) !== m_cnt) begin n_err++; $display("FAIL stall_pre_count got %0d want %0d", c0, m_cnt); end
        stall = 1;
        set_op(1, 2'b11, 0, 3'd0, 5'd7, 32'h5555_5555, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_vec++; if (writedata !== 32'hABCD || writeadd !== 5'd4 || RegWrite !== 2'b01
                         || wb_valid !== 1'b1 || retired_count !== c0) begin
                n_err++; $display("FAIL stall_hold_%0d got %0h@%0d rw=%0h cnt=%0d want abcd@4 rw=1 cnt=%0d",
                                  i, writedata, writeadd, RegWrite, retired_count, c0);
            end
        end
        flush = 1;
        cycle();
        n_vec++; if (RegWrite !== 2'b00 || wb_valid !== 1'b0 || fwd_en !== 1'b0 || retired_count !== c0) begin
            n_err++; $display("FAIL stall_flush got rw=%0h v=%b f=%b cnt=%0d want 0 0 0 %0d",
                              RegWrite, wb_valid, fwd_en, retired_count, c0);
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (m_cnt != (1 << CW) - 1 && guard < 600) begin
            set_op(1, 2'b01, 0, 3'd0, 5'd2, $urandom, 32'h0);
            cycle();
            guard++;
        end
        n_vec++; if (retired_count !== {CW{1'b1}}) begin
            n_err++; $display("FAIL wrap_max got %0d want %0d", retired_count, (1 << CW) - 1);
        end
        cycle();
        n_vec++; if (retired_count !== '0) begin n_err++; $display("FAIL wrap_zero got %0d want 0", retired_count); end
    endtask

    task automatic test_random();
        logic [1:0]  rw;
        logic [31:0] efd;
        for (int i = 0; i < 400; i++) begin
            rw    = 2'($urandom_range(0, 3));
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 9) == 0);
            set_op($urandom_range(0, 9) != 0, rw,
                   (rw == 2'b01 || rw == 2'b11) ? 1'($urandom) : 1'b0,
                   3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), $urandom, $urandom);
            cycle();
            efd = (m_rw == 2'b10) ? {m_wd[15:0], 16'h0} : m_wd;
            n_vec++; if (wb_valid !== m_valid || RegWrite !== m_rw || misalign !== m_mis
                         || int'(retired_count) !== m_cnt) begin
                n_err++; $display("FAIL rand_ctl_%0d got v=%b rw=%0h m=%b c=%0d want v=%b rw=%0h m=%b c=%0d",
                                  i, wb_valid, RegWrite, misalign, retired_count, m_valid, m_rw, m_mis, m_cnt);
            end
            if (m_rw != 2'b00) begin
                n_vec++; if (writedata !== m_wd || writeadd !== m_wa || fwd_en !== 1'b1
                             || fwd_data !== efd || fwd_add !== m_wa) begin
                    n_err++; $display("FAIL rand_data_%0d got %0h@%0d fwd=%0h want %0h@%0d fwd=%0h",
                                      i, writedata, writeadd, fwd_data, m_wd, m_wa, efd);
                end
            end else begin
                n_vec++; if (fwd_en !== 1'b0) begin
                    n_err++; $display("FAIL rand_fwd_%0d got en=%b want 0", i, fwd_en);
                end
            end
        end
        stall = 0; flush = 0;
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_loads();
        test_misalign();
        test_lui_and_zero();
        test_stall_flush();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
